// File: rtl/mlp_pkg.sv
// Shared types and the output saturation helper for the partitioned MLP MAC.
// sat_shift works on fixed wide containers so any DATA_WIDTH up to 60 fits.
package mlp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t FIN   = 2'd3;

    localparam int SAT_IN_W  = 128;
    localparam int SAT_OUT_W = 64;

    // Arithmetic shift right (floor), clamp to a dw-bit signed range, optional ReLU.
    function automatic logic signed [SAT_OUT_W-1:0] sat_shift(
        input logic signed [SAT_IN_W-1:0] acc,
        input int                         dw,
        input int                         frac,
        input logic                       relu
    );
        logic signed [SAT_IN_W-1:0] sh;
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        logic signed [SAT_IN_W-1:0] res;
        sh = acc >>> frac;
        hi = (SAT_IN_W'(1) <<< (dw - 1)) - SAT_IN_W'(1);
        lo = ~hi;
        if (sh > hi)      res = hi;
        else if (sh < lo) res = lo;
        else              res = sh;
        if (relu && res < 0) res = '0;
        return SAT_OUT_W'(res);
    endfunction

endpackage

// File: rtl/mlp_partition_mac_if.sv
// Bus between the partition loaders (master) and the MAC engine (slave).
// start is a request taken only while busy=0; done is a one-cycle completion strobe, no backpressure.
interface mlp_partition_mac_if #(
    parameter int DATA_WIDTH      = 27,
    parameter int ARR_COLUMN_SIZE = 2,
    parameter int PARTITION_SIZE  = 4
);
    logic                                                     start;
    logic                                                     first_part;
    logic                                                     last_part;
    logic                                                     relu_en;
    logic [PARTITION_SIZE-1:0][DATA_WIDTH-1:0]                vec;
    logic [PARTITION_SIZE*ARR_COLUMN_SIZE-1:0][DATA_WIDTH-1:0] wgt;
    logic                                                     busy;
    logic                                                     done;
    logic                                                     out_valid;
    logic [ARR_COLUMN_SIZE-1:0][DATA_WIDTH-1:0]               y;
    mlp_pkg::state_t                                          dbg_state;

    modport master (
        output start, first_part, last_part, relu_en, vec, wgt,
        input  busy, done, out_valid, y, dbg_state
    );

    modport slave (
        input  start, first_part, last_part, relu_en, vec, wgt,
        output busy, done, out_valid, y, dbg_state
    );
endinterface

// File: rtl/mlp_mac_pipe.sv
// Three-stage multiply-accumulate datapath (operand select, product, accumulate)
// feeding a bank of per-neuron accumulators.
module mlp_mac_pipe #(
    parameter int DW    = 27,
    parameter int COLS  = 2,
    parameter int P     = 4,
    parameter int ACC_W = 2*DW+8,
    parameter int CW    = 1,
    parameter int KW    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_issue,
    input  logic                         i_clr,
    input  logic [CW-1:0]                i_c,
    input  logic [KW-1:0]                i_k,
    input  logic [P-1:0][DW-1:0]         i_vec,
    input  logic [COLS*P-1:0][DW-1:0]    i_wgt,
    output logic                         o_busy,
    output logic [COLS-1:0][ACC_W-1:0]   o_acc
);
    localparam int IW = (COLS*P > 1) ? $clog2(COLS*P) : 1;

    logic [IW-1:0]           w_idx;
    logic                    r_s1_v, r_s2_v, r_s3_v;
    logic signed [DW-1:0]    r_s1_a, r_s1_b;
    logic [CW-1:0]           r_s1_c, r_s2_c;
    logic signed [2*DW-1:0]  r_s2_p;
    logic [COLS-1:0][ACC_W-1:0] r_acc;

    assign w_idx = IW'(i_c) * IW'(P) + IW'(i_k);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s3_v <= 1'b0;
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_s1_c <= '0;
            r_s2_c <= '0;
            r_s2_p <= '0;
            r_acc  <= '0;
        end else begin
            r_s1_v <= i_issue;
            r_s2_v <= r_s1_v;
            r_s3_v <= r_s2_v;
            if (i_issue) begin
                r_s1_a <= i_vec[i_k];
                r_s1_b <= i_wgt[w_idx];
                r_s1_c <= i_c;
            end
            if (r_s1_v) begin
                r_s2_p <= (2*DW)'(r_s1_a) * (2*DW)'(r_s1_b);
                r_s2_c <= r_s1_c;
            end
            // Clear only happens in IDLE, when the pipe is already empty.
            if (i_clr)
                r_acc <= '0;
            else if (r_s2_v)
                r_acc[r_s2_c] <= r_acc[r_s2_c] + ACC_W'(r_s2_p);
        end
    end

    assign o_busy = r_s1_v | r_s2_v | r_s3_v;
    assign o_acc  = r_acc;
endmodule

// File: rtl/mlp_partition_mac.sv
// Partition MAC engine: FSM sequencing COLS*P MACs per pass through one multiplier,
// accumulating across partitions and emitting saturated neuron outputs on the last pass.
module mlp_partition_mac
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH      = 27,
    parameter int FRAC_BITS       = 13,
    parameter int ARR_COLUMN_SIZE = 2,
    parameter int PARTITION_SIZE  = 4,
    parameter int ACC_WIDTH       = 2*DATA_WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst,
    mlp_partition_mac_if.slave   bus
);
    localparam int CW = (ARR_COLUMN_SIZE > 1) ? $clog2(ARR_COLUMN_SIZE) : 1;
    localparam int KW = (PARTITION_SIZE > 1) ? $clog2(PARTITION_SIZE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(ARR_COLUMN_SIZE - 1);
    localparam logic [KW-1:0] K_LAST = KW'(PARTITION_SIZE - 1);

    state_t                                     r_state;
    logic [CW-1:0]                              r_c;
    logic [KW-1:0]                              r_k;
    logic                                       r_last;
    logic                                       r_relu;
    logic [ARR_COLUMN_SIZE-1:0][DATA_WIDTH-1:0] r_y;

    logic                                        w_issue;
    logic                                        w_clr;
    logic                                        w_pipe_busy;
    logic [ARR_COLUMN_SIZE-1:0][ACC_WIDTH-1:0]   w_acc;
    logic [ARR_COLUMN_SIZE-1:0][DATA_WIDTH-1:0]  w_y_next;

    assign w_issue = (r_state == RUN);
    assign w_clr   = (r_state == IDLE) && bus.start && bus.first_part;

    mlp_mac_pipe #(
        .DW(DATA_WIDTH), .COLS(ARR_COLUMN_SIZE), .P(PARTITION_SIZE),
        .ACC_W(ACC_WIDTH), .CW(CW), .KW(KW)
    ) u_pipe (
        .clk(clk), .rst(rst),
        .i_issue(w_issue), .i_clr(w_clr),
        .i_c(r_c), .i_k(r_k),
        .i_vec(bus.vec), .i_wgt(bus.wgt),
        .o_busy(w_pipe_busy), .o_acc(w_acc)
    );

    for (genvar g = 0; g < ARR_COLUMN_SIZE; g++) begin : g_out
        logic signed [SAT_OUT_W-1:0] w_sat;
        assign w_sat       = sat_shift(SAT_IN_W'($signed(w_acc[g])), DATA_WIDTH, FRAC_BITS, r_relu);
        assign w_y_next[g] = DATA_WIDTH'(w_sat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_k     <= '0;
            r_last  <= 1'b0;
            r_relu  <= 1'b0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= RUN;
                    r_c     <= '0;
                    r_k     <= '0;
                    r_last  <= bus.last_part;
                    r_relu  <= bus.relu_en;
                end
                RUN: begin
                    if (r_k == K_LAST) begin
                        r_k <= '0;
                        if (r_c == C_LAST) r_state <= DRAIN;
                        else               r_c     <= r_c + CW'(1);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                // Accumulators are final once the pipe is empty, so y loads on entry to FIN.
                DRAIN: if (!w_pipe_busy) begin
                    r_state <= FIN;
                    if (r_last) r_y <= w_y_next;
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == FIN);
    assign bus.out_valid = (r_state == FIN) && r_last;
    assign bus.y         = r_y;
    assign bus.dbg_state = r_state;
endmodule
